// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector for an arbitrary PATTERN of PAT_LEN bits.
// Supports overlap select, a bit-valid qualifier and a saturating match counter.
module moore_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             c,
    input  logic             overlap,
    input  logic             count_clear,
    output logic             d,
    output logic [CNT_W-1:0] match_count
);
    localparam int SW = $clog2(PAT_LEN + 1);

    typedef enum logic [SW-1:0] {
        S_0     = SW'(0),
        S_MATCH = SW'(PAT_LEN)
    } state_t;

    // Bit i of the pattern in wire order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic int next_of(input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic h;
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (i < j) begin
                        idx = k + 1 - j + i;
                        h   = (idx < k) ? pat_bit(idx) : b;
                        if (h != pat_bit(i)) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also one of its suffixes.
    function automatic int fail_len();
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < PAT_LEN; j++) begin
            ok = 1'b1;
            for (int i = 0; i < PAT_LEN; i++) begin
                if (i < j && pat_bit(i) != pat_bit(PAT_LEN - j + i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    localparam logic [SW-1:0]    F_STATE = SW'(fail_len());
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0][SW-1:0] w_tbl0;
    logic [PAT_LEN-1:0][SW-1:0] w_tbl1;

    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_tbl
            assign w_tbl0[gi] = SW'(next_of(gi, 1'b0));
            assign w_tbl1[gi] = SW'(next_of(gi, 1'b1));
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    w_base;
    logic [SW-1:0]    w_cand;
    logic             w_hit;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_base = r_state;
        w_cand = r_state;
        w_next = r_state;
        w_hit  = 1'b0;
        // Leaving the match state: resume from the border or start afresh.
        if (r_state == S_MATCH) begin
            w_base = overlap ? F_STATE : SW'(0);
        end
        for (int k = 0; k < PAT_LEN; k++) begin
            if (w_base == SW'(k)) begin
                w_cand = c ? w_tbl1[k] : w_tbl0[k];
            end
        end
        if (en) begin
            w_next = state_t'(w_cand);
            w_hit  = (w_cand == S_MATCH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (count_clear) begin
            r_count <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && r_count != CNT_MAX) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign d           = (r_state == S_MATCH);
    assign match_count = r_count;

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-type serial pattern detector. It generalises the fixed 1010 detector to any pattern of length PAT_LEN and adds a runtime overlap/non-overlap mode select, an input-valid qualifier and a saturating match counter. It sits on a serial bit stream, one bit per enabled clock, and flags each completed occurrence of PATTERN on a registered, state-decoded output.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 1..16.
- PATTERN, 4'b1010: PAT_LEN-bit pattern; the MSB is the first bit expected on the wire.
- CNT_W, 8: match counter width; must be at least 1.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  bit-valid; c is sampled only on clock edges where en=1.
- c  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every enabled edge.
- count_clear  input  1  synchronous clear of match_count.
- d  output  1  match flag; high while the FSM is in the match state.
- match_count  output  CNT_W  saturating count of match-state entries.

## Operation
- State S_k, k = 0..PAT_LEN, is the number of pattern bits currently matched. S_PAT_LEN is the match state. State register width is $clog2(PAT_LEN+1).
- Bit order: in S_k, the expected bit is PATTERN[PAT_LEN-1-k].
- Transitions from S_k, k < PAT_LEN, on an enabled bit c:
  - If c equals the expected bit, go to S_(k+1).
  - Otherwise go to S_j, where j is the longest prefix of PATTERN that is a suffix of the received history (first k pattern bits followed by c). This is the KMP failure function.
  - The transition table is computed at elaboration from PATTERN. No runtime search.
- Transitions from S_PAT_LEN:
  - overlap=1: behave as S_f, where f is the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - overlap=0: behave as S_0, so the completed match is discarded.
- en=0: state, d and match_count hold. count_clear is still honoured.
- Output d is a Moore output: d = (state == S_PAT_LEN). It does not depend combinationally on c or en.
- match_count:
  - Increments by 1 on every enabled edge whose next state is S_PAT_LEN, including re-entry from S_PAT_LEN.
  - Saturates at 2^CNT_W-1.
  - If count_clear and an increment occur on the same edge, the result is 1.
  - If count_clear occurs with no increment, the result is 0.
- Reset: state = S_0, d = 0, match_count = 0, asynchronously on assertion. The first enabled edge after deassertion is treated as the first bit of a fresh stream. Reset in mid-pattern discards the partial match.

## Timing
- Latency: d rises one clock after the edge that samples the final pattern bit. match_count updates on that same edge.
- d stays high for exactly one clock if the next enabled bit leaves S_PAT_LEN.
- d stays high for more than one clock in these cases:
  - en is low, so the state holds.
  - The pattern self-loops in the match state, e.g. 1111 with overlap=1 and input 1.
- overlap is consulted only on edges leaving S_PAT_LEN. Changing it elsewhere has no effect.
- No combinational path from any input to any output.

## Test plan
- Defaults, overlap=1, en=1, stream 1,0,1,0,1,0 → d high in the cycles after bits 4 and 6 only; match_count=2.
- Defaults, overlap=0, stream 1,0,1,0,1,0,1,0 → d high after bits 4 and 8 only, not after 6; match_count=2.
- PATTERN=4'b1111, overlap=1, six consecutive 1s → d high for 3 consecutive cycles (after bits 4, 5, 6); match_count=3. Same stream with overlap=0 → d high only after bit 4; match_count=1.
- Defaults, stream 1,0,1,0 with en=0 for 3 cycles inserted between each bit → exactly one match; d high from the edge after bit 4 until the next enabled bit. Also: reset pulsed after 1,0,1, then 0 → no match, d=0, match_count=0.
- CNT_W=2, overlap=1, stream 1,0 repeated 6 times (5 matches) → match_count saturates at 3. Then count_clear coincident with the edge completing the next match → match_count=1.
- PAT_LEN=1, PATTERN=1'b1, stream 1,1,0,1 → d high after bits 1, 2 and 4; match_count=3.
